multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multicycle main-control FSM for the byte-capable MIPS core. One ALU and one unified instr/data memory are shared across cycles.
//  Sequences fetch/decode/execute/memory/writeback and drives every datapath strobe and mux select, plus alucontrol and byte_enable.
//  Tolerates a slow memory through a ready handshake with a bounded wait.
// PARAMETERS
//  WAIT_LIMIT  15  max cycles a memory state waits for mem_ready before abort (1..255)
//  CNT_W       8   width of wait counter; must hold WAIT_LIMIT
// PORTS
//  clk         in   1  rising-edge clock
//  reset       in   1  asynchronous, active-low reset (0 = reset)
//  op          in   6  instr[31:26] from instruction register
//  funct       in   6  instr[5:0]
//  zero        in   1  ALU zero flag (ALU output of current cycle)
//  mem_ready   in   1  memory completes access this cycle
//  iord        out  1  mem address select: 0 = PC, 1 = ALUOut
//  memwrite    out  1  memory write strobe
//  irwrite     out  1  instruction register load
//  regdst      out  1  1 = rd, 0 = rt
//  memtoreg    out  1  1 = data reg to RF, 0 = ALUOut
//  regwrite    out  1  register file write
//  alusrca     out  1  0 = PC, 1 = regA
//  alusrcb     out  2  00 regB, 01 const 4, 10 signimm, 11 signimm<<2
//  pcsrc       out  2  00 ALUResult, 01 ALUOut, 10 jump target
//  pcen        out  1  PC load enable (pcwrite | taken branch)
//  alucontrol  out  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
//  byte_enable out  1  1 = byte access (lb/sb)
//  illegal_op  out  1  1-cycle pulse in DECODE on unsupported op/funct
//  mem_timeout out  1  1-cycle pulse when a wait exceeds WAIT_LIMIT
//  state       out  4  current state code (debug)
// BEHAVIOUR
//  States: 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXEC, 7 ALUWB, 8 BRANCH, 9 ADDIEX, 10 ADDIWB, 11 JUMP.
//  Opcodes: R 000000, lw 100011, lb 100000, sw 101011, sb 101000, beq 000100, bne 000101, addi 001000, j 000010.
//  FETCH: iord=0, alusrca=0, alusrcb=01, add, pcsrc=00. irwrite=pcen=1 only in the cycle mem_ready=1; next state is DECODE that cycle, else stay.
//  DECODE: alusrca=0, alusrcb=11, add (branch target to ALUOut).
//   lw/lb/sw/sb -> MEMADR; R -> EXEC; beq/bne -> BRANCH; addi -> ADDIEX; j -> JUMP; other -> FETCH with illegal_op=1.
//  MEMADR: alusrca=1, alusrcb=10, add. Loads -> MEMRD; stores -> MEMWR.
//  MEMRD: iord=1; advance to MEMWB on mem_ready. MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
//  MEMWR: iord=1, memwrite=1 held until mem_ready; then FETCH.
//  EXEC: alusrca=1, alusrcb=00, alucontrol from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt) -> ALUWB.
//   Unknown funct: illegal_op already pulsed in DECODE, so the instruction never reaches EXEC.
//  ALUWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
//  BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01; pcen = beq ? zero : ~zero -> FETCH.
//  ADDIEX: alusrca=1, alusrcb=10, add -> ADDIWB. ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
//  JUMP: pcsrc=10, pcen=1 -> FETCH.
//  Outputs are decoded combinationally from state (plus mem_ready/zero/op). Every strobe not listed for a state is 0; unlisted selects are 0.
//  byte_enable: 1 in MEMADR/MEMRD/MEMWB/MEMWR for lb/sb, else 0.
//  Wait counter: clears on entering FETCH/MEMRD/MEMWR and counts each cycle mem_ready=0.
//   If the count reaches WAIT_LIMIT with mem_ready still 0: mem_timeout=1 for that cycle, next state FETCH.
//   On abort no pcen/irwrite/regwrite; memwrite deasserts next cycle.
//   A FETCH timeout re-fetches the same PC.
//  mem_ready=1 outside memory states is ignored. mem_ready on the same cycle as the timeout edge completes the access; no timeout is raised.
//  Reset (async, any state, including mid-wait): state=FETCH, counter=0, illegal_op=mem_timeout=0.
//   All strobes (pcen, irwrite, regwrite, memwrite) are forced 0 while reset=0. First fetch strobe is possible on the first edge after release.
//  op/funct are sampled from the IR. The datapath holds the IR stable from DECODE through writeback.
// TESTING
//  add (op 0, funct 100000), mem_ready=1 -> states 0,1,6,7,0; regwrite=1, regdst=1 only in ALUWB; alucontrol=0010 in EXEC.
//  lb (op 100000), mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, byte_enable=1 through MEMWB, memtoreg=regwrite=1 once.
//  beq zero=1 -> pcen=1, pcsrc=01 in BRANCH; bne zero=1 -> pcen=0.
//  sw with mem_ready stuck 0, WAIT_LIMIT=15 -> memwrite high 15 cycles, mem_timeout pulses once, next state FETCH, no regwrite.
//  op 111111 -> illegal_op pulse in DECODE, return to FETCH, no pcen/regwrite/memwrite.
//  reset=0 asserted mid MEMWR wait -> memwrite drops immediately (async), state=0; after release, normal fetch of next instruction.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle main-control FSM for the byte-capable MIPS core.
// Sequences fetch/decode/execute/memory/writeback over a shared ALU and a
// unified memory, and bounds every memory wait with a timeout counter.
module multicycle_ctrl #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [3:0] alucontrol,
    output logic       byte_enable,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_SB   = 6'b101000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [5:0] LEGAL_OPS [9] = '{OP_R, OP_LW, OP_LB, OP_SW, OP_SB,
                                            OP_BEQ, OP_BNE, OP_ADDI, OP_J};
    localparam logic [5:0] LEGAL_FUNCTS [5] = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [8:0] op_hit;
    logic [4:0] funct_hit;
    logic       is_r, is_load, is_store, is_byte, instr_legal;
    logic       in_wait, wait_expired;

    // Raw strobes before the reset gate
    logic pcwrite_raw, branch_raw, irwrite_raw, regwrite_raw, memwrite_raw;
    logic illegal_raw, timeout_raw;

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_op_hit
            assign op_hit[gi] = (op == LEGAL_OPS[gi]);
        end
        for (gi = 0; gi < 5; gi++) begin : g_funct_hit
            assign funct_hit[gi] = (funct == LEGAL_FUNCTS[gi]);
        end
    endgenerate

    // R-type with an unsupported funct is rejected in DECODE, so EXEC only sees legal functs
    assign is_r        = (op == OP_R);
    assign is_load     = (op == OP_LW) || (op == OP_LB);
    assign is_store    = (op == OP_SW) || (op == OP_SB);
    assign is_byte     = (op == OP_LB) || (op == OP_SB);
    assign instr_legal = (|op_hit) && (!is_r || (|funct_hit));

    // Memory-wait states share one counter; expiry means this cycle is the last allowed miss
    assign in_wait      = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign wait_expired = in_wait && !mem_ready && (cnt_q == CNT_W'(WAIT_LIMIT - 1));

    // State and wait-counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, datapath selects, raw strobes and wait-counter update
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        iord         = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        alucontrol   = ALU_AND;
        byte_enable  = 1'b0;
        pcwrite_raw  = 1'b0;
        branch_raw   = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        memwrite_raw = 1'b0;
        illegal_raw  = 1'b0;
        timeout_raw  = 1'b0;

        case (state_q)
            S_FETCH: begin
                alusrcb    = 2'b01;
                alucontrol = ALU_ADD;
                if (mem_ready) begin
                    irwrite_raw = 1'b1;
                    pcwrite_raw = 1'b1;
                    state_d     = S_DECODE;
                end else if (wait_expired) begin
                    // PC untouched, so the retry fetches the same address
                    timeout_raw = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
                if (!instr_legal) begin
                    illegal_raw = 1'b1;
                    state_d     = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEMADR;
                end else if (is_r) begin
                    state_d = S_EXEC;
                end else if ((op == OP_BEQ) || (op == OP_BNE)) begin
                    state_d = S_BRANCH;
                end else if (op == OP_ADDI) begin
                    state_d = S_ADDIEX;
                end else begin
                    state_d = S_JUMP;
                end
            end
            S_MEMADR: begin
                alusrca     = 1'b1;
                alusrcb     = 2'b10;
                alucontrol  = ALU_ADD;
                byte_enable = is_byte;
                if (is_load) begin
                    state_d = S_MEMRD;
                end else if (is_store) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                iord        = 1'b1;
                byte_enable = is_byte;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (wait_expired) begin
                    timeout_raw = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
                byte_enable  = is_byte;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
                byte_enable  = is_byte;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (wait_expired) begin
                    timeout_raw = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_EXEC: begin
                alusrca = 1'b1;
                case (funct)
                    F_ADD:   alucontrol = ALU_ADD;
                    F_SUB:   alucontrol = ALU_SUB;
                    F_AND:   alucontrol = ALU_AND;
                    F_OR:    alucontrol = ALU_OR;
                    F_SLT:   alucontrol = ALU_SLT;
                    default: alucontrol = ALU_AND;
                endcase
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                branch_raw = (op == OP_BEQ) ? zero : ~zero;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
                state_d    = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_raw = 1'b1;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                pcsrc       = 2'b10;
                pcwrite_raw = 1'b1;
                state_d     = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Counter restarts on any state change or abort, and only runs while waiting
        if (!in_wait || (state_d != state_q) || timeout_raw) begin
            cnt_d = '0;
        end else if (!mem_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Strobes are held low for the whole time reset is asserted, not just at the edge
    assign pcen        = reset & (pcwrite_raw | branch_raw);
    assign irwrite     = reset & irwrite_raw;
    assign regwrite    = reset & regwrite_raw;
    assign memwrite    = reset & memwrite_raw;
    assign illegal_op  = reset & illegal_raw;
    assign mem_timeout = reset & timeout_raw;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: reset checks, a directed vector table,
// hand-written wait/reset corner sequences and a randomized instruction stream
// whose per-cycle expectations come from an instruction-level trace model.
module tb_multicycle_ctrl;

    localparam int WL = 15;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3;
    localparam logic [3:0] S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEC = 4'd6, S_ALUWB = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8, S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_JUMP = 4'd11;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_LB = 6'b100000;
    localparam logic [5:0] OP_SW = 6'b101011, OP_SB = 6'b101000, OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

    // Strobe vector: {pcen, irwrite, regwrite, memwrite, byte_enable, illegal_op, mem_timeout}
    localparam logic [6:0] P = 7'b1000000, IRW = 7'b0100000, RW = 7'b0010000, MW = 7'b0001000;
    localparam logic [6:0] BE = 7'b0000100, ILL = 7'b0000010, TO = 7'b0000001, NONE = 7'b0000000;

    logic       clk, reset, zero, mem_ready;
    logic [5:0] op, funct;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] alucontrol, state;
    logic       byte_enable, illegal_op, mem_timeout;

    multicycle_ctrl #(.WAIT_LIMIT(WL), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen),
        .alucontrol(alucontrol), .byte_enable(byte_enable), .illegal_op(illegal_op),
        .mem_timeout(mem_timeout), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic       mr;
        logic [3:0] st;
        logic [6:0] stb;
    } vec_t;

    vec_t dir[$];
    vec_t rq[$];
    int   checks = 0;
    int   passed = 0;

    logic [5:0] g_op, g_funct;
    logic       g_zero;

    function automatic vec_t mk(input logic [5:0] o, input logic [5:0] f, input logic z,
                                input logic r, input logic [3:0] s, input logic [6:0] b);
        vec_t v;
        v.op = o; v.funct = f; v.zero = z; v.mr = r; v.st = s; v.stb = b;
        return v;
    endfunction

    // {iord, alusrca, alusrcb, pcsrc, regdst, memtoreg} expected in each state
    function automatic logic [7:0] sel_of(input logic [3:0] s);
        case (s)
            S_FETCH:  return 8'b0001_0000;
            S_DECODE: return 8'b0011_0000;
            S_MEMADR: return 8'b0110_0000;
            S_MEMRD:  return 8'b1000_0000;
            S_MEMWB:  return 8'b0000_0001;
            S_MEMWR:  return 8'b1000_0000;
            S_EXEC:   return 8'b0100_0000;
            S_ALUWB:  return 8'b0000_0010;
            S_BRANCH: return 8'b0100_0100;
            S_ADDIEX: return 8'b0110_0000;
            S_JUMP:   return 8'b0000_1000;
            default:  return 8'b0000_0000;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [3:0] s, input logic [5:0] f);
        if (s == S_FETCH || s == S_DECODE || s == S_MEMADR || s == S_ADDIEX) return 4'b0010;
        if (s == S_BRANCH) return 4'b0110;
        if (s == S_EXEC) begin
            case (f)
                F_ADD:   return 4'b0010;
                F_SUB:   return 4'b0110;
                F_AND:   return 4'b0000;
                F_OR:    return 4'b0001;
                F_SLT:   return 4'b0111;
                default: return 4'b0000;
            endcase
        end
        return 4'b0000;
    endfunction

    function automatic logic [31:0] observed();
        return {9'd0, state, pcen, irwrite, regwrite, memwrite, byte_enable, illegal_op, mem_timeout,
                iord, alusrca, alusrcb, pcsrc, regdst, memtoreg, alucontrol};
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s[%0d]: got %h, expected %h", name, idx, got, exp);
    endtask

    // Drive one cycle's inputs just after the edge, compare on the falling edge
    task automatic step(input vec_t v, input string name, input int idx);
        op = v.op; funct = v.funct; zero = v.zero; mem_ready = v.mr;
        #4;
        chk(name, idx, observed(), {9'd0, v.st, v.stb, sel_of(v.st), alu_of(v.st, v.funct)});
        $display("%s[%0d] op=%b funct=%b zero=%b mr=%b state=%0d", name, idx, v.op, v.funct, v.zero, v.mr, state);
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference trace model ----------------
    function automatic bit op_legal(input logic [5:0] o);
        return o inside {OP_R, OP_LW, OP_LB, OP_SW, OP_SB, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
    endfunction

    function automatic bit funct_legal(input logic [5:0] f);
        return f inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
    endfunction

    task automatic push(input logic r, input logic [3:0] s, input logic [6:0] b);
        rq.push_back(mk(g_op, g_funct, g_zero, r, s, b));
    endtask

    function automatic logic rnd_bit();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return WL + $urandom_range(0, 3);
        if (r == 1) return WL - 1;
        if (r < 6) return 0;
        return $urandom_range(1, WL - 2);
    endfunction

    // An access that misses w times: it either completes on miss-count w < WL,
    // or is aborted on the WL-th consecutive miss
    task automatic mem_access(input logic [3:0] s, input int w, input logic [6:0] busy,
                              input logic [6:0] done, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < w; i++) begin
            if (i == WL - 1) begin
                push(1'b0, s, busy | TO);
                return;
            end
            push(1'b0, s, busy);
        end
        push(1'b1, s, done);
        ok = 1'b1;
    endtask

    task automatic gen_instr();
        int  k;
        bit  ok;
        logic [6:0] be;
        k = $urandom_range(0, 9);
        case (k)
            0: g_op = OP_R;   1: g_op = OP_LW;  2: g_op = OP_LB;   3: g_op = OP_SW;   4: g_op = OP_SB;
            5: g_op = OP_BEQ; 6: g_op = OP_BNE; 7: g_op = OP_ADDI; 8: g_op = OP_J;
            default: begin
                g_op = 6'b111111;
                for (int t = 0; t < 8; t++) begin
                    g_op = 6'($urandom_range(0, 63));
                    if (!op_legal(g_op)) break;
                    g_op = 6'b111111;
                end
            end
        endcase
        if (g_op == OP_R && $urandom_range(0, 7) != 0) begin
            case ($urandom_range(0, 4))
                0: g_funct = F_ADD; 1: g_funct = F_SUB; 2: g_funct = F_AND; 3: g_funct = F_OR;
                default: g_funct = F_SLT;
            endcase
        end else if (g_op == OP_R) begin
            g_funct = 6'h21;
        end else begin
            g_funct = 6'($urandom_range(0, 63));
        end
        g_zero = rnd_bit();
        be = (g_op == OP_LB || g_op == OP_SB) ? BE : NONE;

        mem_access(S_FETCH, pick_wait(), NONE, P | IRW, ok);
        if (!ok) mem_access(S_FETCH, $urandom_range(0, WL - 1), NONE, P | IRW, ok);

        if (!op_legal(g_op) || (g_op == OP_R && !funct_legal(g_funct))) begin
            push(rnd_bit(), S_DECODE, ILL);
            return;
        end
        push(rnd_bit(), S_DECODE, NONE);
        case (g_op)
            OP_R: begin
                push(rnd_bit(), S_EXEC, NONE);
                push(rnd_bit(), S_ALUWB, RW);
            end
            OP_LW, OP_LB: begin
                push(rnd_bit(), S_MEMADR, be);
                mem_access(S_MEMRD, pick_wait(), be, be, ok);
                if (ok) push(rnd_bit(), S_MEMWB, RW | be);
            end
            OP_SW, OP_SB: begin
                push(rnd_bit(), S_MEMADR, be);
                mem_access(S_MEMWR, pick_wait(), MW | be, MW | be, ok);
            end
            OP_BEQ: push(rnd_bit(), S_BRANCH, g_zero ? P : NONE);
            OP_BNE: push(rnd_bit(), S_BRANCH, g_zero ? NONE : P);
            OP_ADDI: begin
                push(rnd_bit(), S_ADDIEX, NONE);
                push(rnd_bit(), S_ADDIWB, RW);
            end
            default: push(rnd_bit(), S_JUMP, P);
        endcase
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] fl [5];
        fl[0] = F_ADD; fl[1] = F_SUB; fl[2] = F_AND; fl[3] = F_OR; fl[4] = F_SLT;

        // Directed table: every row is one cycle starting in FETCH
        for (int i = 0; i < 5; i++) begin
            dir.push_back(mk(OP_R, fl[i], 0, 1, S_FETCH, P | IRW));
            dir.push_back(mk(OP_R, fl[i], 0, 1, S_DECODE, NONE));
            dir.push_back(mk(OP_R, fl[i], 0, 1, S_EXEC, NONE));
            dir.push_back(mk(OP_R, fl[i], 0, 1, S_ALUWB, RW));
        end
        // lb with a slow fetch and three MEMRD misses
        dir.push_back(mk(OP_LB, 0, 0, 0, S_FETCH, NONE));
        dir.push_back(mk(OP_LB, 0, 0, 1, S_FETCH, P | IRW));
        dir.push_back(mk(OP_LB, 0, 0, 0, S_DECODE, NONE));
        dir.push_back(mk(OP_LB, 0, 0, 1, S_MEMADR, BE));
        dir.push_back(mk(OP_LB, 0, 0, 0, S_MEMRD, BE));
        dir.push_back(mk(OP_LB, 0, 0, 0, S_MEMRD, BE));
        dir.push_back(mk(OP_LB, 0, 0, 0, S_MEMRD, BE));
        dir.push_back(mk(OP_LB, 0, 0, 1, S_MEMRD, BE));
        dir.push_back(mk(OP_LB, 0, 0, 1, S_MEMWB, RW | BE));
        // lw, fast
        dir.push_back(mk(OP_LW, 0, 0, 1, S_FETCH, P | IRW));
        dir.push_back(mk(OP_LW, 0, 0, 1, S_DECODE, NONE));
        dir.push_back(mk(OP_LW, 0, 0, 1, S_MEMADR, NONE));
        dir.push_back(mk(OP_LW, 0, 0, 1, S_MEMRD, NONE));
        dir.push_back(mk(OP_LW, 0, 0, 0, S_MEMWB, RW));
        // branches
        dir.push_back(mk(OP_BEQ, 0, 1, 1, S_FETCH, P | IRW));
        dir.push_back(mk(OP_BEQ, 0, 1, 1, S_DECODE, NONE));
        dir.push_back(mk(OP_BEQ, 0, 1, 1, S_BRANCH, P));
        dir.push_back(mk(OP_BNE, 0, 1, 1, S_FETCH, P | IRW));
        dir.push_back(mk(OP_BNE, 0, 1, 1, S_DECODE, NONE));
        dir.push_back(mk(OP_BNE, 0, 1, 1, S_BRANCH, NONE));
        dir.push_back(mk(OP_BEQ, 0, 0, 1, S_FETCH, P | IRW));
        dir.push_back(mk(OP_BEQ, 0, 0, 1, S_DECODE, NONE));
        dir.push_back(mk(OP_BEQ, 0, 0, 1, S_BRANCH, NONE));
        // illegal opcode and illegal funct
        dir.push_back(mk(6'b111111, 0, 0, 1, S_FETCH, P | IRW));
        dir.push_back(mk(6'b111111, 0, 0, 1, S_DECODE, ILL));
        dir.push_back(mk(OP_R, 6'h21, 0, 1, S_FETCH, P | IRW));
        dir.push_back(mk(OP_R, 6'h21, 0, 1, S_DECODE, ILL));
        // addi, j, sb
        dir.push_back(mk(OP_ADDI, 0, 0, 1, S_FETCH, P | IRW));
        dir.push_back(mk(OP_ADDI, 0, 0, 1, S_DECODE, NONE));
        dir.push_back(mk(OP_ADDI, 0, 0, 1, S_ADDIEX, NONE));
        dir.push_back(mk(OP_ADDI, 0, 0, 1, S_ADDIWB, RW));
        dir.push_back(mk(OP_J, 0, 0, 1, S_FETCH, P | IRW));
        dir.push_back(mk(OP_J, 0, 0, 0, S_DECODE, NONE));
        dir.push_back(mk(OP_J, 0, 0, 0, S_JUMP, P));
        dir.push_back(mk(OP_SB, 0, 0, 1, S_FETCH, P | IRW));
        dir.push_back(mk(OP_SB, 0, 0, 1, S_DECODE, NONE));
        dir.push_back(mk(OP_SB, 0, 0, 0, S_MEMADR, BE));
        dir.push_back(mk(OP_SB, 0, 0, 1, S_MEMWR, MW | BE));

        // Reset: strobes must stay low even with mem_ready high
        reset = 1'b0; op = OP_R; funct = F_ADD; zero = 1'b0; mem_ready = 1'b1;
        #2;
        chk("reset_early", 0, {25'd0, state, pcen, irwrite, regwrite, memwrite, illegal_op, mem_timeout, 1'b0}, 32'd0);
        #15;
        chk("reset_held", 0, {25'd0, state, pcen, irwrite, regwrite, memwrite, illegal_op, mem_timeout, 1'b0}, 32'd0);
        #5;
        reset = 1'b1;
        #1;
        chk("first_fetch", 0, {26'd0, state, pcen, irwrite}, {26'd0, S_FETCH, 1'b1, 1'b1});
        @(posedge clk);
        #1;
        step(mk(OP_R, F_ADD, 0, 1, S_DECODE, NONE), "post_reset", 0);
        step(mk(OP_R, F_ADD, 0, 1, S_EXEC, NONE), "post_reset", 1);
        step(mk(OP_R, F_ADD, 0, 1, S_ALUWB, RW), "post_reset", 2);

        for (int i = 0; i < dir.size(); i++) step(dir[i], "dir", i);

        // sw with memory stuck busy: memwrite for WL cycles, timeout on the last, back to FETCH
        step(mk(OP_SW, 0, 0, 1, S_FETCH, P | IRW), "sw_to", 0);
        step(mk(OP_SW, 0, 0, 0, S_DECODE, NONE), "sw_to", 1);
        step(mk(OP_SW, 0, 0, 0, S_MEMADR, NONE), "sw_to", 2);
        for (int i = 0; i < WL; i++)
            step(mk(OP_SW, 0, 0, 0, S_MEMWR, (i == WL - 1) ? (MW | TO) : MW), "sw_to", 3 + i);
        step(mk(OP_SW, 0, 0, 0, S_FETCH, NONE), "sw_to", 3 + WL);

        // Reset asserted mid MEMWR wait: memwrite drops at once, then a normal fetch follows
        step(mk(OP_SW, 0, 0, 1, S_FETCH, P | IRW), "rst_mid", 0);
        step(mk(OP_SW, 0, 0, 0, S_DECODE, NONE), "rst_mid", 1);
        step(mk(OP_SW, 0, 0, 0, S_MEMADR, NONE), "rst_mid", 2);
        for (int i = 0; i < 3; i++) step(mk(OP_SW, 0, 0, 0, S_MEMWR, MW), "rst_mid", 3 + i);
        #3;
        chk("rst_mid_before", 0, {27'd0, state, memwrite}, {27'd0, S_MEMWR, 1'b1});
        reset = 1'b0;
        #1;
        chk("rst_mid_async", 0, {25'd0, state, memwrite, pcen, irwrite}, {25'd0, S_FETCH, 3'b000});
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        step(mk(OP_R, F_ADD, 0, 1, S_FETCH, P | IRW), "rst_mid", 6);
        step(mk(OP_R, F_ADD, 0, 1, S_DECODE, NONE), "rst_mid", 7);
        step(mk(OP_R, F_ADD, 0, 1, S_EXEC, NONE), "rst_mid", 8);
        step(mk(OP_R, F_ADD, 0, 1, S_ALUWB, RW), "rst_mid", 9);

        // Randomized instruction stream against the trace model
        for (int n = 0; n < 150; n++) gen_instr();
        for (int i = 0; i < rq.size(); i++) step(rq[i], "rand", i);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
